// File: rtl/matrix_col_driver_pkg.sv
// Shared definitions for the LED matrix stages: default geometry, FSM encoding
// and common index/pattern types.
package matrix_pkg;

    localparam int MATRIX_ROWS      = 7;
    localparam int MATRIX_COLS      = 5;
    localparam int MATRIX_BLANK_CYC = 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    typedef logic [2:0]             row_idx_t;
    typedef logic [MATRIX_COLS-1:0] col_pattern_t;

endpackage

// File: rtl/matrix_col_driver_if.sv
// Frame-store write port and bank-swap handshake of the column driver.
interface matrix_col_driver_if import matrix_pkg::*; #(
    parameter int COLS = MATRIX_COLS
);
    logic            wr_en;
    row_idx_t        wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;

    modport master (output wr_en, wr_row, wr_data, swap_req, input swap_ack);
    modport slave  (input wr_en, wr_row, wr_data, swap_req, output swap_ack);
endinterface

// File: rtl/matrix_col_driver_row_decode.sv
// Active-low one-hot row select to row index; valid only when exactly one line is low.
module row_onehot_decode import matrix_pkg::*; #(
    parameter int ROWS = MATRIX_ROWS
) (
    input  logic [ROWS-1:0] row_n_i,
    output row_idx_t        idx_o,
    output logic            vld_o
);
    logic [ROWS-1:0] sel;

    always_comb begin
        sel   = ~row_n_i;
        vld_o = (sel != '0) && ((sel & (sel - ROWS'(1))) == '0);
        idx_o = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (sel[i]) idx_o = row_idx_t'(i);
        end
    end
endmodule

// File: rtl/matrix_col_driver.sv
// Column driver for the 5x7 matrix: double-buffered frame store, blanking FSM and
// frame-boundary bank swap. Optional dimming PWM when MATRIX_DIM_EN is defined.
module matrix_col_driver import matrix_pkg::*; #(
    parameter int ROWS      = MATRIX_ROWS,
    parameter int COLS      = MATRIX_COLS,
    parameter int BLANK_CYC = MATRIX_BLANK_CYC
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic [ROWS-1:0]   row_n,
`ifdef MATRIX_DIM_EN
    input  logic [1:0]        dim,
`endif
    matrix_col_driver_if.slave bus,
    output logic [COLS-1:0]   col,
    output logic              frame_tick,
    output logic              row_err
);
    localparam logic [1:0] BCNT_INIT = 2'(BLANK_CYC);
    localparam logic [1:0] BCNT_RLD  = (BLANK_CYC == 0) ? 2'd0 : 2'(BLANK_CYC - 1);

    logic [COLS-1:0] bank_q [2][ROWS];
    logic            front_sel_q, front_sel_d;
    logic            pend_q, pend_d;
    logic            prev_vld_q;
    row_idx_t        prev_row_q;
    logic [0:0]      state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [COLS-1:0] col_q, col_d;
    logic            swap_ack_q, frame_tick_q, row_err_q;

    row_idx_t        idx;
    logic            vld, row_chg, boundary, do_swap, wr_ok, wr_bank;
    logic [COLS-1:0] pat, show_pat;

    row_onehot_decode #(.ROWS(ROWS)) u_decode (
        .row_n_i (row_n),
        .idx_o   (idx),
        .vld_o   (vld)
    );

`ifdef MATRIX_DIM_EN
    logic [1:0] pwm_q;
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_q + 2'd1;
    end
`endif

    always_comb begin
        row_chg     = vld && (!prev_vld_q || idx != prev_row_q);
        boundary    = row_chg && prev_vld_q && idx == '0;
        do_swap     = boundary && (pend_q || bus.swap_req);
        front_sel_d = front_sel_q ^ do_swap;
        pend_d      = do_swap ? 1'b0 : (pend_q | bus.swap_req);
        wr_ok       = bus.wr_en && (int'(bus.wr_row) < ROWS);
        wr_bank     = ~front_sel_q;

        // A same-cycle write into the bank that is about to become front is forwarded.
        pat = bank_q[front_sel_d][idx];
        if (wr_ok && wr_bank == front_sel_d && bus.wr_row == idx) pat = bus.wr_data;
`ifdef MATRIX_DIM_EN
        show_pat = (pwm_q <= dim) ? pat : '0;
`else
        show_pat = pat;
`endif

        state_d = state_q;
        bcnt_d  = bcnt_q;
        col_d   = '0;
        if (!vld) begin
            state_d = ST_BLANK;
            bcnt_d  = BCNT_INIT;
        end else if (row_chg) begin
            // The row-change cycle itself is the first blank cycle.
            if (BLANK_CYC == 0) begin
                state_d = ST_SHOW;
                col_d   = show_pat;
            end else begin
                state_d = ST_BLANK;
                bcnt_d  = BCNT_RLD;
            end
        end else if (state_q == ST_SHOW || bcnt_q == 2'd0) begin
            state_d = ST_SHOW;
            col_d   = show_pat;
        end else begin
            bcnt_d = bcnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    bank_q[b][r] <= '0;
            front_sel_q  <= 1'b0;
            pend_q       <= 1'b0;
            prev_vld_q   <= 1'b0;
            prev_row_q   <= '0;
            state_q      <= ST_BLANK;
            bcnt_q       <= BCNT_INIT;
            col_q        <= '0;
            swap_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            row_err_q    <= 1'b0;
        end else begin
            if (wr_ok) bank_q[wr_bank][bus.wr_row] <= bus.wr_data;
            front_sel_q  <= front_sel_d;
            pend_q       <= pend_d;
            if (vld) begin
                prev_vld_q <= 1'b1;
                prev_row_q <= idx;
            end
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            col_q        <= col_d;
            swap_ack_q   <= do_swap;
            frame_tick_q <= boundary;
            row_err_q    <= !vld;
        end
    end

    assign bus.swap_ack = swap_ack_q;
    assign col          = col_q;
    assign frame_tick   = frame_tick_q;
    assign row_err      = row_err_q;
endmodule

// File: tb/tb_matrix_col_driver.sv
// Directed scoreboard bench for matrix_col_driver (BLANK_CYC=1 and BLANK_CYC=2 instances).
module tb_matrix_col_driver;
    import matrix_pkg::*;

    logic       clk_div = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] row_n1 = 7'b1111011;
    logic [6:0] row_n2 = 7'b1111110;
    logic [4:0] col1, col2;
    logic       ft1, ft2, re1, re2;
`ifdef MATRIX_DIM_EN
    logic [1:0] dim1 = 2'd3;
    logic [1:0] dim2 = 2'd3;
`endif

    matrix_col_driver_if #(.COLS(5)) bus1 ();
    matrix_col_driver_if #(.COLS(5)) bus2 ();

    matrix_col_driver #(.ROWS(7), .COLS(5), .BLANK_CYC(1)) u_dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .row_n      (row_n1),
`ifdef MATRIX_DIM_EN
        .dim        (dim1),
`endif
        .bus        (bus1.slave),
        .col        (col1),
        .frame_tick (ft1),
        .row_err    (re1)
    );

    matrix_col_driver #(.ROWS(7), .COLS(5), .BLANK_CYC(2)) u_dut2 (
        .clk_div    (clk_div),
        .rst        (rst),
        .row_n      (row_n2),
`ifdef MATRIX_DIM_EN
        .dim        (dim2),
`endif
        .bus        (bus2.slave),
        .col        (col2),
        .frame_tick (ft2),
        .row_err    (re2)
    );

    always #5 clk_div = ~clk_div;

    typedef struct {
        string      tag;
        logic [4:0] col;
        logic       ft;
        logic       sa;
        logic       re;
    } exp_t;

    exp_t       sb1[$];
    logic [4:0] sb2[$];
    int         ncmp  = 0;
    int         nfail = 0;

    function automatic logic [6:0] rs(input int r);
        logic [6:0] one;
        one = 7'b0000001;
        return ~(one << r);
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] rn, input logic we,
                        input logic [2:0] wrow, input logic [4:0] wd, input logic sreq,
                        input logic [4:0] ec, input logic eft, input logic esa, input logic ere);
        exp_t e;
        row_n1        = rn;
        bus1.wr_en    = we;
        bus1.wr_row   = wrow;
        bus1.wr_data  = wd;
        bus1.swap_req = sreq;
        sb1.push_back('{tag, ec, eft, esa, ere});
        @(posedge clk_div);
        #1;
        e = sb1.pop_front();
        chk({e.tag, "_col"}, col1, e.col);
        chk({e.tag, "_ftick"}, {4'd0, ft1}, {4'd0, e.ft});
        chk({e.tag, "_sack"}, {4'd0, bus1.swap_ack}, {4'd0, e.sa});
        chk({e.tag, "_rerr"}, {4'd0, re1}, {4'd0, e.re});
    endtask

    // Row change with BLANK_CYC=1: one dark cycle, then the pattern.
    task automatic show(input string tag, input int r, input logic sreq,
                        input logic [4:0] ec, input logic eft, input logic esa);
        step({tag, "_blank"}, rs(r), 1'b0, 3'd0, 5'd0, sreq, 5'd0, eft, esa, 1'b0);
        step({tag, "_show"},  rs(r), 1'b0, 3'd0, 5'd0, 1'b0, ec, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step2(input string tag, input int r, input logic we, input logic [2:0] wrow,
                         input logic [4:0] wd, input logic sreq, input logic [4:0] ec, input logic esa);
        logic [4:0] e;
        row_n2        = rs(r);
        bus2.wr_en    = we;
        bus2.wr_row   = wrow;
        bus2.wr_data  = wd;
        bus2.swap_req = sreq;
        sb2.push_back(ec);
        @(posedge clk_div);
        #1;
        e = sb2.pop_front();
        chk({tag, "_col"}, col2, e);
        chk({tag, "_sack"}, {4'd0, bus2.swap_ack}, {4'd0, esa});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.wr_en = 1'b0; bus1.wr_row = '0; bus1.wr_data = '0; bus1.swap_req = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_row = '0; bus2.wr_data = '0; bus2.swap_req = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_col", col1, 5'd0);
        step("rst_hold", rs(2), 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Load back bank (bank 1) with 0x10+k while front (bank 0, cleared) stays dark
        step("p1_w0", rs(0), 1'b1, 3'd0, 5'h10, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 7; k++)
            step($sformatf("p1_w%0d", k), rs(0), 1'b1, 3'(k), 5'(16 + k), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        show("p1_r1", 1, 1'b1, 5'd0, 1'b0, 1'b0);
        show("p1_r0", 0, 1'b0, 5'h10, 1'b1, 1'b1);

        // Load new back bank (bank 0) with k+1; front row 0 keeps showing 0x10
        for (int k = 0; k < 7; k++)
            step($sformatf("p2_w%0d", k), rs(0), 1'b1, 3'(k), 5'(k + 1), 1'b0, 5'h10, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 7; k++)
            show($sformatf("p2_old_r%0d", k), k, (k == 3), 5'(16 + k), 1'b0, 1'b0);
        show("p2_swap_r0", 0, 1'b0, 5'h01, 1'b1, 1'b1);
        for (int k = 1; k < 7; k++)
            show($sformatf("p2_new_r%0d", k), k, 1'b0, 5'(k + 1), 1'b0, 1'b0);

        // Invalid row selects, then the same row again must blank before showing
        step("p3_none",  7'b1111111, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("p3_multi", 7'b1111100, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("p3_back",  rs(6),      1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("p3_show",  rs(6),      1'b0, 3'd0, 5'd0, 1'b0, 5'h07, 1'b0, 1'b0, 1'b0);

        // Write in the swap cycle lands in the new front; wr_row=7 is ignored
        step("p4_req",   rs(1), 1'b0, 3'd0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0);
        step("p4_wr7",   rs(1), 1'b1, 3'd7, 5'h0A, 1'b0, 5'h02, 1'b0, 1'b0, 1'b0);
        step("p4_swap",  rs(0), 1'b1, 3'd0, 5'h1F, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0);
        step("p4_r0",    rs(0), 1'b0, 3'd0, 5'd0,  1'b0, 5'h1F, 1'b0, 1'b0, 1'b0);
        show("p4_r1", 1, 1'b0, 5'h11, 1'b0, 1'b0);
        show("p4_r6", 6, 1'b0, 5'h16, 1'b0, 1'b0);
        show("p4_wrap", 0, 1'b0, 5'h1F, 1'b1, 1'b0);

        // Mid-scan reset with a pending swap: everything cleared at once
        step("p5_pend", rs(0), 1'b0, 3'd0, 5'd0, 1'b1, 5'h1F, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("p5_async_col", col1, 5'd0);
        chk("p5_async_ftick", {4'd0, ft1}, 5'd0);
        chk("p5_async_sack", {4'd0, bus1.swap_ack}, 5'd0);
        chk("p5_async_rerr", {4'd0, re1}, 5'd0);
        @(posedge clk_div);
        #1 rst = 1'b0;
        show("p5_r1", 1, 1'b0, 5'd0, 1'b0, 1'b0);
        show("p5_r0", 0, 1'b0, 5'd0, 1'b1, 1'b0);

        // BLANK_CYC=2 instance: two dark cycles on 1111110 -> 1111101
        step2("b2_wr",   0, 1'b1, 3'd1, 5'h0B, 1'b0, 5'd0, 1'b0);
        step2("b2_r1a",  1, 1'b0, 3'd0, 5'd0,  1'b1, 5'd0, 1'b0);
        step2("b2_r1b",  1, 1'b0, 3'd0, 5'd0,  1'b0, 5'd0, 1'b0);
        step2("b2_r1c",  1, 1'b0, 3'd0, 5'd0,  1'b0, 5'd0, 1'b0);
        step2("b2_sw",   0, 1'b0, 3'd0, 5'd0,  1'b0, 5'd0, 1'b1);
        step2("b2_r0b",  0, 1'b0, 3'd0, 5'd0,  1'b0, 5'd0, 1'b0);
        step2("b2_r0c",  0, 1'b0, 3'd0, 5'd0,  1'b0, 5'd0, 1'b0);
        step2("b2_bl1",  1, 1'b0, 3'd0, 5'd0,  1'b0, 5'd0, 1'b0);
        step2("b2_bl2",  1, 1'b0, 3'd0, 5'd0,  1'b0, 5'd0, 1'b0);
        step2("b2_show", 1, 1'b0, 3'd0, 5'd0,  1'b0, 5'h0B, 1'b0);

`ifdef MATRIX_DIM_EN
        // dim=1: two cycles on, two off, locked to the first on-cycle
        begin
            int n;
            dim2 = 2'd1;
            n = 0;
            while (col2 !== 5'd0 && n < 8) begin @(posedge clk_div); #1; n++; end
            while (col2 !== 5'h0B && n < 8) begin @(posedge clk_div); #1; n++; end
            chk("dim_sync_col", col2, 5'h0B);
            step2("dim_on2",  1, 1'b0, 3'd0, 5'd0, 1'b0, 5'h0B, 1'b0);
            step2("dim_off1", 1, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0,  1'b0);
            step2("dim_off2", 1, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0,  1'b0);
            step2("dim_on3",  1, 1'b0, 3'd0, 5'd0, 1'b0, 5'h0B, 1'b0);
            step2("dim_on4",  1, 1'b0, 3'd0, 5'd0, 1'b0, 5'h0B, 1'b0);
            step2("dim_off3", 1, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0,  1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
